// File: rtl/approx_div_16x8_seq_pkg.sv
// approx_div_16x8_seq_pkg: shared state encoding and error fill value for the sequential dividers
package approx_div_16x8_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;
    localparam logic [7:0] ERR_FILL = 8'hFF;
endpackage

// File: rtl/approx_div_16x8_seq_restore_step.sv
// div_restore_step: one restoring-division step; ports rem/bit_in/D in, rem_next/qbit out
module div_restore_step (
    input  logic [7:0] rem,
    input  logic       bit_in,
    input  logic [7:0] D,
    output logic [7:0] rem_next,
    output logic       qbit
);
    logic [8:0] t;
    always_comb begin
        t        = {rem, bit_in};
        qbit     = t >= {1'b0, D};
        rem_next = qbit ? 8'(t - {1'b0, D}) : t[7:0];
    end
endmodule

// File: rtl/approx_div_16x8_seq.sv
// approx_div_16x8_seq: 16/8 sequential restoring divider with truncated low quotient bits; valid/ready in (N, D) and out (Q, R, err)
module approx_div_16x8_seq
    import approx_div_16x8_seq_pkg::*;
#(
    parameter int APPROX_LSB = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] N,
    input  logic [7:0]  D,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  Q,
    output logic [7:0]  R,
    output logic        err
);
    localparam int ITER = 8 - APPROX_LSB;
    localparam logic [2:0] LAST = 3'(ITER - 1);
    state_t state;
    logic ld;
    logic [7:0] d_r, rem, sh, qacc, rem_next;
    logic [2:0] cnt;
    logic qbit;
    div_restore_step u_step (
        .rem(rem),
        .bit_in(sh[7]),
        .D(d_r),
        .rem_next(rem_next),
        .qbit(qbit)
    );
    // the cycle after accept (ld) decides between the error path and the iterations
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            ld        <= 1'b0;
            d_r       <= '0;
            rem       <= '0;
            sh        <= '0;
            qacc      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Q         <= '0;
            R         <= '0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    rem      <= N[15:8];
                    sh       <= N[7:0];
                    d_r      <= D;
                    qacc     <= '0;
                    cnt      <= '0;
                    ld       <= 1'b1;
                    in_ready <= 1'b0;
                    state    <= BUSY;
                end
                BUSY: if (ld) begin
                    ld <= 1'b0;
                    if (d_r == 8'd0 || rem >= d_r) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Q         <= ERR_FILL;
                        R         <= ERR_FILL;
                        err       <= 1'b1;
                    end
                end else begin
                    rem  <= rem_next;
                    sh   <= {sh[6:0], 1'b0};
                    qacc <= {qacc[6:0], qbit};
                    cnt  <= cnt + 3'd1;
                    if (cnt == LAST) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Q         <= 8'({qacc[6:0], qbit} << APPROX_LSB);
                        R         <= rem_next;
                        err       <= 1'b0;
                    end
                end
                DONE: if (out_ready) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_div_16x8_seq.sv
// tb_approx_div_16x8_seq: directed and random checks of approx_div_16x8_seq at APPROX_LSB 0 and 2
module tb_approx_div_16x8_seq;
    logic clk, rst, out_ready;
    logic [15:0] N;
    logic [7:0] D;
    logic iv[2], ir[2], ov[2], e[2];
    logic [7:0] q[2], r[2];
    int nvec, nfail;
    approx_div_16x8_seq #(.APPROX_LSB(0)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .N(N), .D(D),
        .out_valid(ov[0]), .out_ready(out_ready), .Q(q[0]), .R(r[0]), .err(e[0])
    );
    approx_div_16x8_seq #(.APPROX_LSB(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .N(N), .D(D),
        .out_valid(ov[1]), .out_ready(out_ready), .Q(q[1]), .R(r[1]), .err(e[1])
    );
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nfail++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic div(input int i, input logic [15:0] n, input logic [7:0] d, input int hold);
        logic [7:0] eq, er;
        logic ee;
        int k, lat, cyc;
        k = i * 2;
        if (d == 0 || n[15:8] >= d) begin
            eq = 8'hFF; er = 8'hFF; ee = 1'b1; lat = 1;
        end else begin
            eq = 8'(((n >> k) / d) << k); er = 8'((n >> k) % d); ee = 1'b0; lat = 9 - k;
        end
        @(negedge clk);
        N = n; D = d; iv[i] = 1'b1;
        chk("in_ready_idle", ir[i], 1);
        @(posedge clk);
        #1 iv[i] = 1'b0;
        cyc = 0;
        while (cyc < 30 && !ov[i]) begin
            @(posedge clk);
            cyc++;
            #1;
        end
        chk("latency", cyc, lat);
        chk("Q", q[i], eq);
        chk("R", r[i], er);
        chk("err", e[i], ee);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            N = 16'hFFFF; D = 8'd1; iv[i] = 1'b1;
            @(posedge clk);
            #1;
            chk("hold_valid", ov[i], 1);
            chk("hold_ready", ir[i], 0);
            chk("hold_Q", q[i], eq);
            chk("hold_R", r[i], er);
            chk("hold_err", e[i], ee);
        end
        @(negedge clk);
        iv[i] = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        chk("valid_drop", ov[i], 0);
        chk("ready_back", ir[i], 1);
    endtask
    initial begin
        nvec = 0; nfail = 0;
        rst = 1'b1; out_ready = 1'b0; N = '0; D = '0; iv[0] = 1'b0; iv[1] = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("rst_in_ready", ir[i], 1);
            chk("rst_out_valid", ov[i], 0);
            chk("rst_Q", q[i], 0);
            chk("rst_R", r[i], 0);
            chk("rst_err", e[i], 0);
        end
        @(negedge clk) rst = 1'b0;
        div(0, 16'd1000, 8'd7, 0);
        div(1, 16'd1000, 8'd7, 0);
        div(0, 16'h0800, 8'd8, 0);
        div(0, 16'd123, 8'd0, 0);
        div(0, 16'd65279, 8'd255, 0);
        div(0, 16'd0, 8'd1, 0);
        div(1, 16'd65279, 8'd255, 0);
        div(0, 16'd1000, 8'd7, 5);
        div(0, 16'd500, 8'd3, 0);
        @(negedge clk);
        N = 16'd4000; D = 8'd77; iv[0] = 1'b1;
        @(posedge clk);
        #1 iv[0] = 1'b0;
        repeat (4) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_out_valid", ov[0], 0);
        chk("arst_in_ready", ir[0], 1);
        chk("arst_Q", q[0], 0);
        chk("arst_R", r[0], 0);
        chk("arst_err", e[0], 0);
        @(negedge clk) rst = 1'b0;
        div(0, 16'd1000, 8'd7, 0);
        for (int j = 0; j < 40; j++) begin
            logic [7:0] d;
            logic [15:0] n;
            d = 8'($urandom_range(0, 255));
            n = 16'($urandom_range(0, 65535));
            if (j % 4 != 0 && d != 0) n[15:8] = 8'($urandom_range(0, d - 1));
            div(j % 2, n, d, (j % 7 == 0) ? 2 : 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
